// File: rtl/reg_write_arbiter_if.sv
// Writeback request bus between the two requesters (ALU, memory load) and
// the register write-port arbiter.
//   master : requester side, drives valid/addr/data, receives ready
//   slave  : arbiter side, receives valid/addr/data, drives ready
interface reg_write_arbiter_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
);
    logic              mem_valid;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic              mem_ready;

    logic              alu_valid;
    logic [ADDR_W-1:0] alu_addr;
    logic [DATA_W-1:0] alu_data;
    logic              alu_ready;

    modport master (
        output mem_valid, mem_addr, mem_data,
        output alu_valid, alu_addr, alu_data,
        input  mem_ready, alu_ready
    );

    modport slave (
        input  mem_valid, mem_addr, mem_data,
        input  alu_valid, alu_addr, alu_data,
        output mem_ready, alu_ready
    );
endinterface

// File: rtl/reg_write_arbiter.sv
// Register file write-port arbiter with pending-write scoreboard.
// Two writeback sources (memory load, ALU) share one register file write
// port; grants are combinational, the write port is driven from one
// registered stage. A per-register busy bit tracks outstanding producers.
//
// Ports:
//   clk          : clock, rising edge
//   rst          : synchronous active-low reset
//   req          : slave side of the writeback request bus (valid/addr/data/ready)
//   issue_valid  : instruction with a destination register issues this cycle
//   issue_addr   : destination register of the issuing instruction
//   busy_vec     : bit n set while register n has a pending write
//   reg_write    : register file write enable (registered)
//   write_addr   : register file write address (registered)
//   write_data   : register file write data (registered)
//
// Build option: define REG_WRITE_ARB_STARVE_EN to enable the ALU starvation
// counter; otherwise arbitration is fixed priority, memory over ALU.
module reg_write_arbiter #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned ADDR_W     = 5,
    parameter int unsigned STARVE_MAX = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    reg_write_arbiter_if.slave       req,
    input  logic                     issue_valid,
    input  logic [ADDR_W-1:0]        issue_addr,
    output logic [(2**ADDR_W)-1:0]   busy_vec,
    output logic                     reg_write,
    output logic [ADDR_W-1:0]        write_addr,
    output logic [DATA_W-1:0]        write_data
);
    localparam int unsigned NREG  = 2 ** ADDR_W;
    localparam int unsigned CNT_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

    logic              alu_force_c;
    logic              mem_grant_c;
    logic              alu_grant_c;
    logic              xfer_c;
    logic [ADDR_W-1:0] sel_addr_c;
    logic [DATA_W-1:0] sel_data_c;
    logic [NREG-1:0]   busy_nxt_c;

`ifdef REG_WRITE_ARB_STARVE_EN
    logic [CNT_W-1:0]  starve_cnt;
    logic [CNT_W-1:0]  starve_nxt_c;

    // ALU wins a contended cycle once it has lost STARVE_MAX in a row
    assign alu_force_c = req.mem_valid && req.alu_valid &&
                         (starve_cnt == CNT_W'(STARVE_MAX));

    // Loss counter: clears whenever the ALU is not contending or wins
    always_comb begin
        starve_nxt_c = starve_cnt;
        if (!req.alu_valid || alu_grant_c) begin
            starve_nxt_c = '0;
        end else if (mem_grant_c && (starve_cnt != CNT_W'(STARVE_MAX))) begin
            starve_nxt_c = starve_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            starve_cnt <= '0;
        end else begin
            starve_cnt <= starve_nxt_c;
        end
    end
`else
    assign alu_force_c = 1'b0;
`endif

    // Grants; both held low during reset so held requests re-arbitrate on release
    assign mem_grant_c = rst && req.mem_valid && !alu_force_c;
    assign alu_grant_c = rst && req.alu_valid && !mem_grant_c;
    assign xfer_c      = mem_grant_c || alu_grant_c;
    assign sel_addr_c  = mem_grant_c ? req.mem_addr : req.alu_addr;
    assign sel_data_c  = mem_grant_c ? req.mem_data : req.alu_data;

    assign req.mem_ready = mem_grant_c;
    assign req.alu_ready = alu_grant_c;

    // Scoreboard update: clear on write, then set on issue so a new producer wins
    always_comb begin
        busy_nxt_c = busy_vec;
        if (reg_write) begin
            busy_nxt_c[write_addr] = 1'b0;
        end
        if (issue_valid && (issue_addr != '0)) begin
            busy_nxt_c[issue_addr] = 1'b1;
        end
        busy_nxt_c[0] = 1'b0;
    end

    // Write port stage and scoreboard registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            reg_write  <= 1'b0;
            write_addr <= '0;
            write_data <= '0;
            busy_vec   <= '0;
        end else begin
            busy_vec <= busy_nxt_c;
            if (xfer_c && (sel_addr_c != '0)) begin
                reg_write  <= 1'b1;
                write_addr <= sel_addr_c;
                write_data <= sel_data_c;
            end else begin
                reg_write  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed self-checking bench for reg_write_arbiter.
module tb_reg_write_arbiter;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 5;

    logic              clk;
    logic              rst;
    logic              issue_valid;
    logic [ADDR_W-1:0] issue_addr;
    logic [31:0]       busy_vec;
    logic              reg_write;
    logic [ADDR_W-1:0] write_addr;
    logic [DATA_W-1:0] write_data;

    int n_checks = 0;
    int n_fail   = 0;

    reg_write_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    reg_write_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .STARVE_MAX(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (bus.slave),
        .issue_valid (issue_valid),
        .issue_addr  (issue_addr),
        .busy_vec    (busy_vec),
        .reg_write   (reg_write),
        .write_addr  (write_addr),
        .write_data  (write_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic exp_alu;
        rst = 1'b0;
        issue_valid = 1'b0;
        issue_addr  = '0;
        bus.mem_valid = 1'b1; bus.mem_addr = 5'd3; bus.mem_data = 32'h0000_AAAA;
        bus.alu_valid = 1'b1; bus.alu_addr = 5'd4; bus.alu_data = 32'h0000_BBBB;

        // Reset held two cycles with both requesters valid
        for (int i = 0; i < 2; i++) begin
            tick();
            check("rst_mem_ready", 64'(bus.mem_ready), 64'd0);
            check("rst_alu_ready", 64'(bus.alu_ready), 64'd0);
            check("rst_reg_write", 64'(reg_write), 64'd0);
            check("rst_busy_vec", 64'(busy_vec), 64'd0);
        end
        rst = 1'b1;
        #1;
        check("rel_mem_ready", 64'(bus.mem_ready), 64'd1);
        check("rel_alu_ready", 64'(bus.alu_ready), 64'd0);
        tick();
        bus.mem_valid = 1'b0;
        bus.alu_valid = 1'b0;
        check("rel_reg_write", 64'(reg_write), 64'd1);
        check("rel_write_addr", 64'(write_addr), 64'd3);

        // Single ALU write
        bus.alu_valid = 1'b1; bus.alu_addr = 5'd5; bus.alu_data = 32'hDEAD_BEEF;
        #1;
        check("alu_ready", 64'(bus.alu_ready), 64'd1);
        check("alu_mem_ready", 64'(bus.mem_ready), 64'd0);
        tick();
        bus.alu_valid = 1'b0;
        check("alu_reg_write", 64'(reg_write), 64'd1);
        check("alu_write_addr", 64'(write_addr), 64'd5);
        check("alu_write_data", 64'(write_data), 64'hDEAD_BEEF);

        // Write to register 0: accepted, never written
        bus.mem_valid = 1'b1; bus.mem_addr = 5'd0; bus.mem_data = 32'h0000_1234;
        #1;
        check("r0_mem_ready", 64'(bus.mem_ready), 64'd1);
        tick();
        bus.mem_valid = 1'b0;
        check("r0_reg_write", 64'(reg_write), 64'd0);
        check("r0_write_addr_hold", 64'(write_addr), 64'd5);
        check("r0_write_data_hold", 64'(write_data), 64'hDEAD_BEEF);
        check("r0_busy0", 64'(busy_vec[0]), 64'd0);
        tick();

        // Continuous contention: mem addr 1, ALU addr 2
        bus.mem_valid = 1'b1; bus.mem_addr = 5'd1; bus.mem_data = 32'h0000_0011;
        bus.alu_valid = 1'b1; bus.alu_addr = 5'd2; bus.alu_data = 32'h0000_0022;
        for (int i = 0; i < 8; i++) begin
`ifdef REG_WRITE_ARB_STARVE_EN
            exp_alu = ((i % 4) == 3);
`else
            exp_alu = 1'b0;
`endif
            #1;
            check($sformatf("starve_mem_ready_%0d", i), 64'(bus.mem_ready), 64'(!exp_alu));
            check($sformatf("starve_alu_ready_%0d", i), 64'(bus.alu_ready), 64'(exp_alu));
            tick();
            check($sformatf("starve_write_addr_%0d", i), 64'(write_addr), exp_alu ? 64'd2 : 64'd1);
        end
        bus.mem_valid = 1'b0;
        bus.alu_valid = 1'b0;
        tick();

        // Scoreboard: issue 7, ALU writes 7 two cycles later
        issue_valid = 1'b1; issue_addr = 5'd7;
        tick();
        issue_valid = 1'b0;
        check("sb_set7", 64'(busy_vec[7]), 64'd1);
        tick();
        bus.alu_valid = 1'b1; bus.alu_addr = 5'd7; bus.alu_data = 32'h0000_0077;
        check("sb_hold7", 64'(busy_vec[7]), 64'd1);
        tick();
        bus.alu_valid = 1'b0;
        check("sb_pulse_reg_write", 64'(reg_write), 64'd1);
        check("sb_pulse_busy7", 64'(busy_vec[7]), 64'd1);
        tick();
        check("sb_clear7", 64'(busy_vec[7]), 64'd0);

        // Re-issue of 7 on the clearing edge keeps the bit set
        issue_valid = 1'b1; issue_addr = 5'd7;
        tick();
        issue_valid = 1'b0;
        check("sb_reset7", 64'(busy_vec[7]), 64'd1);
        bus.alu_valid = 1'b1; bus.alu_addr = 5'd7; bus.alu_data = 32'h0000_0078;
        tick();
        bus.alu_valid = 1'b0;
        check("sb2_reg_write", 64'(reg_write), 64'd1);
        issue_valid = 1'b1; issue_addr = 5'd7;
        tick();
        issue_valid = 1'b0;
        check("sb_set_wins", 64'(busy_vec[7]), 64'd1);
        check("sb_vec", 64'(busy_vec), 64'h0000_0080);

        // Reset while a write pulse is in flight and register 9 is busy
        issue_valid = 1'b1; issue_addr = 5'd9;
        tick();
        issue_valid = 1'b0;
        bus.mem_valid = 1'b1; bus.mem_addr = 5'd9;  bus.mem_data = 32'h0000_0099;
        bus.alu_valid = 1'b1; bus.alu_addr = 5'd10; bus.alu_data = 32'h0000_00AA;
        tick();
        check("mid_reg_write", 64'(reg_write), 64'd1);
        check("mid_busy9", 64'(busy_vec[9]), 64'd1);
        bus.mem_addr = 5'd11; bus.mem_data = 32'h0000_00BB;
        rst = 1'b0;
        #1;
        check("mid_rst_mem_ready", 64'(bus.mem_ready), 64'd0);
        check("mid_rst_alu_ready", 64'(bus.alu_ready), 64'd0);
        tick();
        check("mid_reg_write_clr", 64'(reg_write), 64'd0);
        check("mid_busy_clr", 64'(busy_vec), 64'd0);
        check("mid_write_addr_clr", 64'(write_addr), 64'd0);
        check("mid_write_data_clr", 64'(write_data), 64'd0);
`ifdef REG_WRITE_ARB_STARVE_EN
        check("mid_starve_cnt", 64'(dut.starve_cnt), 64'd0);
`endif
        rst = 1'b1;
        #1;
        check("mid_rel_mem_ready", 64'(bus.mem_ready), 64'd1);
        check("mid_rel_alu_ready", 64'(bus.alu_ready), 64'd0);
        tick();
        bus.mem_valid = 1'b0;
        bus.alu_valid = 1'b0;
        check("mid_rel_write_addr", 64'(write_addr), 64'd11);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/reg_write_arbiter.md
# reg_write_arbiter

Shares the register file's single write port between two writeback requesters: the ALU result path and the memory-load path. It also keeps a 32-entry pending-write scoreboard so the issue stage can stall on registers with an outstanding producer. It sits between the writeback sources and the register file write inputs (`reg_write`, `write_addr`, `write_data`), with one registered stage in front of the port.

## Interface
- `DATA_W`, default 32: writeback data width.
- `ADDR_W`, default 5: register address width. Register count is 2^ADDR_W.
- `STARVE_MAX`, default 3: consecutive ALU losses before the ALU is forced to win.

Ports:
- `clk` in 1: single clock. All state updates on the rising edge.
- `rst` in 1: synchronous, active-low reset, sampled on the rising edge of `clk`.
- `mem_valid` in 1: load writeback request.
- `mem_addr` in ADDR_W: load destination register.
- `mem_data` in DATA_W: load data.
- `mem_ready` out 1: load request accepted this cycle.
- `alu_valid` in 1: ALU writeback request.
- `alu_addr` in ADDR_W: ALU destination register.
- `alu_data` in DATA_W: ALU data.
- `alu_ready` out 1: ALU request accepted this cycle.
- `issue_valid` in 1: an instruction with a register destination issues this cycle.
- `issue_addr` in ADDR_W: destination of the issuing instruction.
- `busy_vec` out 2^ADDR_W: bit n = 1 while register n has a pending write.
- `reg_write` out 1: register file write enable.
- `write_addr` out ADDR_W: register file write address.
- `write_data` out DATA_W: register file write data.

## Operation
- Grant is combinational each cycle. `mem_ready` and `alu_ready` are the grants, and at most one is high.
- Default priority is mem over ALU.
  - If only one requester is valid, it is granted.
  - If neither is valid, there is no grant.
- A transfer occurs when valid and ready are both high. Requesters hold addr and data stable until accepted.
- Starvation counter `starve_cnt` is 0..STARVE_MAX.
  - It increments when both are valid and mem wins.
  - It clears when the ALU is granted, or when `alu_valid` = 0.
  - While `starve_cnt` = STARVE_MAX and both are valid, the ALU wins.
- Output stage: on an accepted transfer with addr ≠ 0, the next edge sets `reg_write` = 1 and loads `write_addr` and `write_data`. Otherwise the next edge sets `reg_write` = 0, and `write_addr`/`write_data` hold their previous values.
- A transfer to addr 0 is accepted (ready = 1) but never produces `reg_write`.
- Scoreboard, `busy_vec`, registered:
  - On an edge with `issue_valid` and `issue_addr` ≠ 0, bit `issue_addr` is set.
  - On an edge where the registered `reg_write` = 1, bit `write_addr` is cleared.
  - If set and clear hit the same bit on the same edge, the set wins, because the new producer supersedes the old one.
  - Bit 0 is always 0.
- Reset (`rst` = 0 at an edge) applies regardless of in-flight requests:
  - `reg_write` = 0, `write_addr` = 0, `write_data` = 0.
  - `busy_vec` = 0, `starve_cnt` = 0.
- `mem_ready` and `alu_ready` are forced to 0 while `rst` = 0.
- A request held through reset is re-arbitrated on the first cycle after release.

## Timing
- Accept to `reg_write` pulse: 1 cycle. Register file write: 2nd edge after accept.
- `issue_valid` to `busy_vec` bit set: 1 cycle.
- Accept to `busy_vec` bit clear: 2 cycles, i.e. the edge on which the register file captures the data.
- Throughput: one write per cycle, with back-to-back grants allowed.
- With both valid continuously and the starvation feature enabled, grants follow mem×STARVE_MAX then ALU×1, repeating.

## Configuration
- `REG_WRITE_ARB_STARVE_EN` defined: the starvation counter is present and behaves as above.
- Not defined: no counter, pure fixed priority with mem over ALU. The ALU can be starved indefinitely.

## Test plan
- Reset values: hold `rst` = 0 for 2 cycles with both valid.
  - Required: readies 0, `reg_write` = 0, `busy_vec` = 0.
  - After release: `mem_ready` = 1 in the first cycle.
- Single ALU write: `alu_valid`, addr 5, data 0xDEADBEEF.
  - Required: `alu_ready` = 1 same cycle.
  - Next cycle: `reg_write` = 1, `write_addr` = 5, `write_data` = 0xDEADBEEF.
- Starvation, with `REG_WRITE_ARB_STARVE_EN` defined and STARVE_MAX = 3: both valid continuously, mem addr 1, ALU addr 2.
  - Required grant sequence: M, M, M, A, M, M, M, A.
  - Without the macro: only M.
- Address 0: `mem_valid` with addr 0, data 0x1234.
  - Required: `mem_ready` = 1, `reg_write` stays 0, `busy_vec[0]` = 0.
- Scoreboard: issue addr 7, then ALU write to 7 two cycles later.
  - Required: `busy_vec[7]` = 1 from cycle 1, cleared on the edge after the `reg_write` pulse.
  - Re-issue of 7 on the same edge as the clear leaves the bit = 1.
- Reset mid-operation: assert `rst` = 0 in the cycle `reg_write` = 1 with `busy_vec[9]` = 1.
  - Required: next cycle `reg_write` = 0, `busy_vec` = 0, counter 0.
